vx_tcu_drl_kstep_ctrl: RTL and testbench
========================================

Name: VX_tcu_drl_kstep_ctrl

Overview:
- Sequences one dot-product tile job through the TCU DRL FEDP datapath (exponent/bias, align, CSA, normalize stages) across K steps.
- Accepts a job (format, step count, initial C), pulls per-step A-row/B-col operands from an operand stream and issues them to the datapath.
- Feeds each step's FP32 result back as the next step's C term, then returns the final accumulator.
- Sits between the TCU dispatch/operand buffer and the FEDP pipeline instance.

Parameters:
- N, 2, 32-bit operand words per row/col per step (TCK = 2*N)
- LATENCY, 4, fixed FEDP pipeline depth in cycles, dp_valid to res_valid; >=1
- MAX_K, 16, max steps per job
- TAG_W, 8, job tag width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  job request valid
- req_ready  out  1  controller can accept job
- req_fmtf  in  3  TCU format id (TF32/FP16/BF16/FP8/BF8)
- req_nsteps  in  $clog2(MAX_K+1)  number of K steps
- req_c_val  in  32  initial FP32 accumulator
- req_tag  in  TAG_W  job tag
- op_valid  in  1  operand beat valid
- op_ready  out  1  operand beat consumed
- op_a_row  in  N*32  A-row words
- op_b_col  in  N*32  B-col words
- op_vld_mask  in  TCU_MAX_INPUTS  per-lane valid mask
- dp_valid  out  1  issue to datapath
- dp_fmtf  out  3  format to datapath
- dp_a_row, dp_b_col  out  N*32  operands
- dp_c_val  out  32  C term for this step
- dp_vld_mask  out  TCU_MAX_INPUTS  lane mask
- res_valid  in  1  datapath result valid
- res_data  in  32  datapath FP32 result
- rsp_valid  out  1  job done
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  32  final accumulator
- rsp_tag  out  TAG_W  echoed tag
- rsp_err  out  1  unsupported fmtf

Behaviour:
- Reset: state IDLE; req_ready=1, op_ready=0, dp_valid=0, rsp_valid=0, rsp_data/rsp_tag/rsp_err=0, step counter=0, accumulator=0. A reset mid-job abandons it; any res_valid arriving after reset is ignored.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: req_ready=1.
  - On req_valid, latch fmtf/nsteps/c_val/tag; acc<=req_c_val; k<=0.
  - Unsupported fmtf (not one of the 5 ids): rsp_err=1, rsp_data=req_c_val, go RESP.
  - nsteps==0: rsp_data=req_c_val, rsp_err=0, go RESP.
  - Otherwise go ISSUE.
- ISSUE: op_ready=1. On op_valid&&op_ready, in the same cycle: dp_valid=1 with dp_* driven combinationally from op_* and dp_c_val=acc, dp_fmtf=latched fmtf. Then go WAIT. dp_valid is a single-cycle pulse; the datapath has no backpressure.
- WAIT: count cycles since issue.
  - On res_valid: acc<=res_data, k<=k+1. If k+1==nsteps go RESP with rsp_data=res_data; else go ISSUE.
  - res_valid in any state other than WAIT is ignored.
- Only one step is in flight at a time (C dependency). Per-step throughput is 1 + LATENCY cycles plus operand stall.
- RESP: rsp_valid=1 and held stable until rsp_ready; then IDLE. req_ready=0 and op_ready=0 outside IDLE and ISSUE respectively.
- Watchdog: if WAIT exceeds LATENCY+1 cycles without res_valid, go RESP with rsp_err=1 and rsp_data=acc (simulation assertion also fires).
- Step counter width: $clog2(MAX_K+1); nsteps>MAX_K is clamped to MAX_K.

Optional Feature:
- Macro: TCU_DRL_ZERO_SKIP_EN
- With the macro: in ISSUE, a beat whose op_vld_mask is all-zero is consumed with op_ready, but dp_valid stays 0. acc is unchanged, k increments, and the step costs 1 cycle (no WAIT).
- Without the macro: every beat is issued to the datapath regardless of mask.

Decomposition:
- VX_tcu_pkg adds a kstep_state_t enum (IDLE/ISSUE/WAIT/RESP) and an is_valid_fmtf(fmtf) function over the existing TCU_*_ID constants.
- No sub-module; the watchdog counter stays inline.

Test Plan:
- FP16 job, nsteps=3, c=0x3F800000; datapath model returns 0x40000000, 0x40400000, 0x40800000 -> rsp_data=0x40800000, 3 dp_valid pulses, dp_c_val sequence 3F800000/40000000/40400000.
- nsteps=0, c=0x12345678, tag=0x5A -> rsp_valid within 1 cycle of accept, data=0x12345678, tag=0x5A, no dp_valid.
- fmtf=7 -> rsp_err=1, rsp_data=req_c_val, no op_ready.
- op_valid withheld 5 cycles in ISSUE, and rsp_ready held low 4 cycles -> no dp_valid until op_valid; rsp_valid/rsp_data stable until accepted.
- Model drops res_valid -> rsp_err=1 after LATENCY+2 cycles in WAIT; reset asserted mid-WAIT -> IDLE next cycle, a late res_valid does not alter state.
- ZERO_SKIP build, BF8 nsteps=2, step-0 mask=0 -> single dp_valid, rsp_data=that step's res_data.

Source files
------------

// File: rtl/vx_tcu_drl_kstep_ctrl_pkg.sv
// Shared types and TCU format ids for the DRL K-step controller.
// Provides the controller state enum and the supported-format check.
package vx_tcu_drl_kstep_ctrl_pkg;

  localparam int TCU_MAX_INPUTS = 8;

  localparam logic [2:0] TCU_TF32_ID = 3'd0;
  localparam logic [2:0] TCU_FP16_ID = 3'd1;
  localparam logic [2:0] TCU_BF16_ID = 3'd2;
  localparam logic [2:0] TCU_FP8_ID  = 3'd3;
  localparam logic [2:0] TCU_BF8_ID  = 3'd4;

  typedef enum logic [1:0] {
    KS_IDLE  = 2'd0,
    KS_ISSUE = 2'd1,
    KS_WAIT  = 2'd2,
    KS_RESP  = 2'd3
  } kstep_state_t;

  function automatic logic is_valid_fmtf(input logic [2:0] fmtf);
    case (fmtf)
      TCU_TF32_ID, TCU_FP16_ID, TCU_BF16_ID, TCU_FP8_ID, TCU_BF8_ID: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/vx_tcu_drl_kstep_ctrl.sv
// K-step sequencer for one FEDP tile job: issues per-step operands and chains each result into the next C term.
// Optional TCU_DRL_ZERO_SKIP_EN: all-zero-mask beats are consumed without a datapath issue.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// KS_IDLE  | ready for a job; latches format, step count, C and tag
// KS_ISSUE | waiting for an operand beat; issues it to the datapath
// KS_WAIT  | one step in flight; watchdog counts down to terminal count
// KS_RESP  | final accumulator presented until the consumer accepts it
module vx_tcu_drl_kstep_ctrl
  import vx_tcu_drl_kstep_ctrl_pkg::*;
#(
  parameter int N       = 2,
  parameter int LATENCY = 4,
  parameter int MAX_K   = 16,
  parameter int TAG_W   = 8,
  localparam int KW     = $clog2(MAX_K + 1)
) (
  input  logic                      clk,
  input  logic                      reset,

  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [2:0]                req_fmtf,
  input  logic [KW-1:0]             req_nsteps,
  input  logic [31:0]               req_c_val,
  input  logic [TAG_W-1:0]          req_tag,

  input  logic                      op_valid,
  output logic                      op_ready,
  input  logic [N*32-1:0]           op_a_row,
  input  logic [N*32-1:0]           op_b_col,
  input  logic [TCU_MAX_INPUTS-1:0] op_vld_mask,

  output logic                      dp_valid,
  output logic [2:0]                dp_fmtf,
  output logic [N*32-1:0]           dp_a_row,
  output logic [N*32-1:0]           dp_b_col,
  output logic [31:0]               dp_c_val,
  output logic [TCU_MAX_INPUTS-1:0] dp_vld_mask,

  input  logic                      res_valid,
  input  logic [31:0]               res_data,

  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [31:0]               rsp_data,
  output logic [TAG_W-1:0]          rsp_tag,
  output logic                      rsp_err
);

  localparam int WD_W = $clog2(LATENCY + 2);
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(LATENCY + 1);
  localparam logic [KW-1:0]   K_MAX   = KW'(MAX_K);

  kstep_state_t     state;
  logic [2:0]       fmtf_q;
  logic [KW-1:0]    nsteps_q;
  logic [KW-1:0]    k_q;
  logic [31:0]      acc_q;
  logic [TAG_W-1:0] tag_q;
  logic [WD_W-1:0]  wd_q;

  logic             op_fire;
  logic             skip_beat;
  logic             issue_fire;
  logic [KW-1:0]    k_inc;
  logic [KW-1:0]    req_nsteps_clamped;
  logic             req_fmt_ok;

  assign op_fire = op_valid && op_ready;

`ifdef TCU_DRL_ZERO_SKIP_EN
  assign skip_beat = op_fire && (op_vld_mask == '0);
`else
  assign skip_beat = 1'b0;
`endif

  assign issue_fire         = op_fire && !skip_beat;
  assign k_inc              = k_q + KW'(1);
  assign req_nsteps_clamped = (req_nsteps > K_MAX) ? K_MAX : req_nsteps;
  assign req_fmt_ok         = is_valid_fmtf(req_fmtf);

  // The datapath has no backpressure, so the issue is a same-cycle pass-through of the accepted beat.
  assign dp_valid    = issue_fire;
  assign dp_fmtf     = fmtf_q;
  assign dp_a_row    = op_a_row;
  assign dp_b_col    = op_b_col;
  assign dp_c_val    = acc_q;
  assign dp_vld_mask = op_vld_mask;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= KS_IDLE;
      req_ready <= 1'b1;
      op_ready  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_tag   <= '0;
      rsp_err   <= 1'b0;
      fmtf_q    <= '0;
      nsteps_q  <= '0;
      k_q       <= '0;
      acc_q     <= '0;
      tag_q     <= '0;
      wd_q      <= '0;
    end else begin
      case (state)
        KS_IDLE: begin
          if (req_valid) begin
            fmtf_q    <= req_fmtf;
            nsteps_q  <= req_nsteps_clamped;
            acc_q     <= req_c_val;
            tag_q     <= req_tag;
            k_q       <= '0;
            req_ready <= 1'b0;
            if (!req_fmt_ok || req_nsteps_clamped == '0) begin
              state     <= KS_RESP;
              rsp_valid <= 1'b1;
              rsp_data  <= req_c_val;
              rsp_tag   <= req_tag;
              rsp_err   <= !req_fmt_ok;
            end else begin
              state    <= KS_ISSUE;
              op_ready <= 1'b1;
            end
          end
        end

        KS_ISSUE: begin
          if (issue_fire) begin
            state    <= KS_WAIT;
            op_ready <= 1'b0;
            wd_q     <= WD_LOAD;
          end else if (skip_beat) begin
            // Skipped beat: the step counts but the accumulator carries over untouched.
            k_q <= k_inc;
            if (k_inc == nsteps_q) begin
              state     <= KS_RESP;
              op_ready  <= 1'b0;
              rsp_valid <= 1'b1;
              rsp_data  <= acc_q;
              rsp_tag   <= tag_q;
              rsp_err   <= 1'b0;
            end
          end
        end

        KS_WAIT: begin
          if (res_valid) begin
            acc_q <= res_data;
            k_q   <= k_inc;
            if (k_inc == nsteps_q) begin
              state     <= KS_RESP;
              rsp_valid <= 1'b1;
              rsp_data  <= res_data;
              rsp_tag   <= tag_q;
              rsp_err   <= 1'b0;
            end else begin
              state    <= KS_ISSUE;
              op_ready <= 1'b1;
            end
          end else if (wd_q == '0) begin
            // Lost result: report the last good accumulator rather than hang the tile.
            state     <= KS_RESP;
            rsp_valid <= 1'b1;
            rsp_data  <= acc_q;
            rsp_tag   <= tag_q;
            rsp_err   <= 1'b1;
          end else begin
            wd_q <= wd_q - WD_W'(1);
          end
        end

        KS_RESP: begin
          if (rsp_ready) begin
            state     <= KS_IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end

        default: state <= KS_IDLE;
      endcase
    end
  end

`ifdef TCU_DRL_WDOG_ASSERT
  // Enabled in integration sims, where a missing datapath result is always a bug.
  wdog_no_timeout: assert property (@(posedge clk) disable iff (reset)
    !(state == KS_WAIT && !res_valid && wd_q == '0));
`endif

endmodule

// File: tb/tb_vx_tcu_drl_kstep_ctrl.sv
// Bench for the K-step controller: job-level accumulator model, a latency-accurate datapath stub,
// and directed jobs covering chaining, empty/bad jobs, stalls, watchdog, mid-job reset and clamping.
module tb_vx_tcu_drl_kstep_ctrl;
  import vx_tcu_drl_kstep_ctrl_pkg::*;

  localparam int N       = 2;
  localparam int LATENCY = 4;
  localparam int MAX_K   = 16;
  localparam int TAG_W   = 8;
  localparam int KW      = $clog2(MAX_K + 1);
  localparam int MI      = TCU_MAX_INPUTS;

  logic clk = 1'b0;
  logic reset;
  logic req_valid, req_ready;
  logic [2:0] req_fmtf;
  logic [KW-1:0] req_nsteps;
  logic [31:0] req_c_val;
  logic [TAG_W-1:0] req_tag;
  logic op_valid, op_ready;
  logic [N*32-1:0] op_a_row, op_b_col;
  logic [MI-1:0] op_vld_mask;
  logic dp_valid;
  logic [2:0] dp_fmtf;
  logic [N*32-1:0] dp_a_row, dp_b_col;
  logic [31:0] dp_c_val;
  logic [MI-1:0] dp_vld_mask;
  logic res_valid;
  logic [31:0] res_data;
  logic rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic rsp_err;

  always #5 clk = ~clk;

  vx_tcu_drl_kstep_ctrl #(.N(N), .LATENCY(LATENCY), .MAX_K(MAX_K), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_fmtf(req_fmtf), .req_nsteps(req_nsteps),
    .req_c_val(req_c_val), .req_tag(req_tag),
    .op_valid(op_valid), .op_ready(op_ready), .op_a_row(op_a_row), .op_b_col(op_b_col),
    .op_vld_mask(op_vld_mask),
    .dp_valid(dp_valid), .dp_fmtf(dp_fmtf), .dp_a_row(dp_a_row), .dp_b_col(dp_b_col),
    .dp_c_val(dp_c_val), .dp_vld_mask(dp_vld_mask),
    .res_valid(res_valid), .res_data(res_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .rsp_err(rsp_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Job-level model: the accumulator is C until a result returns, then the latest result.
  logic [31:0]      m_acc;
  logic [2:0]       m_fmtf;
  logic [TAG_W-1:0] m_tag;
  bit               m_bad, m_wait;

  int cyc = 0;
  int dp_cnt, opr_cnt, rsp_rise, accept_cyc;
  int dp_cyc_q[$];
  logic [31:0] dpc_q[$];
  bit rsp_prev = 1'b0;
  bit op_hs = 1'b0;
  bit dp_seen = 1'b0;
  bit exp_dp;

  int beats_left = 0, beat_no = 0, stall = 0;
  logic [MI-1:0] mask_tab [0:MAX_K-1];
  logic [32:0] res_q[$];   // bit 32 set: the datapath drops this result
  int pend = 0;

  function automatic logic [N*32-1:0] a_of(input int b);
    logic [N*32-1:0] v;
    for (int i = 0; i < N; i++) v[i*32 +: 32] = 32'hA000_0000 + 32'(b * 16 + i);
    return v;
  endfunction

  function automatic logic [N*32-1:0] b_of(input int b);
    logic [N*32-1:0] v;
    for (int i = 0; i < N; i++) v[i*32 +: 32] = 32'hB000_0000 + 32'(b * 16 + i);
    return v;
  endfunction

  // Compare process: every cycle, away from the active edge.
  initial forever begin
    @(negedge clk);
    cyc++;
    op_hs = op_valid && op_ready;
    if (!reset) begin
      if (req_valid && req_ready) accept_cyc = cyc;
      if (op_ready) opr_cnt++;
      exp_dp = op_valid && op_ready;
`ifdef TCU_DRL_ZERO_SKIP_EN
      exp_dp = exp_dp && (op_vld_mask != '0);
`endif
      chk("dp_valid", dp_valid, exp_dp);
      if (dp_valid) begin
        dp_seen = 1'b1;
        dp_cnt++;
        dp_cyc_q.push_back(cyc);
        dpc_q.push_back(dp_c_val);
        chk("dp_c_val", dp_c_val, m_acc);
        chk("dp_fmtf", dp_fmtf, m_fmtf);
        chk("dp_a_row", dp_a_row, a_of(beat_no));
        chk("dp_b_col", dp_b_col, b_of(beat_no));
        chk("dp_vld_mask", dp_vld_mask, mask_tab[beat_no % MAX_K]);
        m_wait = 1'b1;
      end
      if (res_valid && m_wait) begin
        m_acc  = res_data;
        m_wait = 1'b0;
      end
      if (rsp_valid) begin
        if (!rsp_prev) rsp_rise = cyc;
        chk("rsp_data", rsp_data, m_acc);
        chk("rsp_tag", rsp_tag, m_tag);
        chk("rsp_err", rsp_err, m_bad || m_wait);
      end
      rsp_prev = rsp_valid;
    end
  end

  // Datapath stub: a result LATENCY cycles after each issue.
  initial begin
    logic [32:0] r;
    res_valid = 1'b0;
    res_data  = '0;
    forever begin
      @(posedge clk); #1;
      res_valid = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0 && res_q.size() > 0) begin
          r = res_q.pop_front();
          if (!r[32]) begin
            res_valid = 1'b1;
            res_data  = r[31:0];
          end
        end
      end
      if (dp_seen) begin
        dp_seen = 1'b0;
        pend = LATENCY - 1;
      end
    end
  end

  // Operand stream: beat b carries a_of(b)/b_of(b) and mask_tab[b].
  initial begin
    op_valid = 1'b0;
    op_a_row = '0;
    op_b_col = '0;
    op_vld_mask = '0;
    forever begin
      @(posedge clk); #1;
      if (op_hs) begin
        beats_left--;
        beat_no++;
      end
      if (stall > 0) begin
        stall--;
        op_valid = 1'b0;
      end else begin
        op_valid = (beats_left > 0);
      end
      op_a_row    = a_of(beat_no);
      op_b_col    = b_of(beat_no);
      op_vld_mask = mask_tab[beat_no % MAX_K];
    end
  end

  task automatic start_job(input logic [2:0] f, input logic [KW-1:0] ns, input logic [31:0] c,
                           input logic [TAG_W-1:0] t, input int nb, input int st);
    int w;
    m_acc = c; m_fmtf = f; m_tag = t; m_bad = (f > 3'd4); m_wait = 1'b0;
    dp_cnt = 0; opr_cnt = 0; rsp_rise = -1; accept_cyc = -1;
    dp_cyc_q.delete();
    dpc_q.delete();
    @(posedge clk); #1;
    req_valid = 1'b1; req_fmtf = f; req_nsteps = ns; req_c_val = c; req_tag = t;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!req_ready && w < 50);
    chk("req_accept", req_ready, 1'b1);
    beats_left = nb; beat_no = 0; stall = st;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic finish_job(input int hold, input int n_dp);
    int w;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!rsp_valid && w < 400);
    chk("rsp_arrive", rsp_valid, 1'b1);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      @(negedge clk);
      chk("rsp_held", rsp_valid, 1'b1);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("rsp_release", rsp_valid, 1'b0);
    chk("req_ready_back", req_ready, 1'b1);
    chk("dp_count", dp_cnt, n_dp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal;
  end

  initial begin
    int w;
    for (int i = 0; i < MAX_K; i++) mask_tab[i] = '1;
    reset = 1'b1; req_valid = 1'b0; req_fmtf = '0; req_nsteps = '0; req_c_val = '0; req_tag = '0;
    rsp_ready = 1'b0;
    m_acc = '0; m_fmtf = '0; m_tag = '0; m_bad = 1'b0; m_wait = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_op_ready", op_ready, 1'b0);
    chk("rst_dp_valid", dp_valid, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_rsp_tag", rsp_tag, 8'h0);
    chk("rst_rsp_err", rsp_err, 1'b0);

    // FP16 chain of three steps
    res_q.push_back({1'b0, 32'h4000_0000});
    res_q.push_back({1'b0, 32'h4040_0000});
    res_q.push_back({1'b0, 32'h4080_0000});
    start_job(3'd1, KW'(3), 32'h3F80_0000, 8'h11, 3, 0);
    finish_job(0, 3);
    chk("fp16_rsp_lit", rsp_data, 32'h4080_0000);
    chk("fp16_c0_lit", dpc_q[0], 32'h3F80_0000);
    chk("fp16_c1_lit", dpc_q[1], 32'h4000_0000);
    chk("fp16_c2_lit", dpc_q[2], 32'h4040_0000);
    chk("fp16_first_issue", dp_cyc_q[0] - accept_cyc, 1);
    chk("fp16_step_period", dp_cyc_q[1] - dp_cyc_q[0], 5);

    // Empty job
    start_job(3'd2, KW'(0), 32'h1234_5678, 8'h5A, 0, 0);
    finish_job(0, 0);
    chk("empty_rsp_delay", rsp_rise - accept_cyc, 1);
    chk("empty_tag_lit", rsp_tag, 8'h5A);
    chk("empty_data_lit", rsp_data, 32'h1234_5678);

    // Unsupported format
    start_job(3'd7, KW'(3), 32'hCAFE_F00D, 8'h33, 0, 0);
    finish_job(0, 0);
    chk("badfmt_op_ready_cycles", opr_cnt, 0);
    chk("badfmt_err_lit", rsp_err, 1'b1);
    chk("badfmt_data_lit", rsp_data, 32'hCAFE_F00D);

    // Operand stall and response backpressure
    res_q.push_back({1'b0, 32'h3F00_0000});
    res_q.push_back({1'b0, 32'h3E80_0000});
    start_job(3'd0, KW'(2), 32'h40A0_0000, 8'h44, 2, 5);
    finish_job(4, 2);
    chk("stall_first_issue", dp_cyc_q[0] - accept_cyc, 6);
    chk("stall_rsp_lit", rsp_data, 32'h3E80_0000);

    // Dropped result trips the watchdog
    res_q.push_back({1'b0, 32'h4110_0000});
    res_q.push_back({1'b1, 32'h0});
    start_job(3'd2, KW'(2), 32'h4100_0000, 8'h77, 2, 0);
    finish_job(0, 2);
    chk("wdog_err_lit", rsp_err, 1'b1);
    chk("wdog_data_lit", rsp_data, 32'h4110_0000);
    chk("wdog_delay", rsp_rise - dp_cyc_q[1], LATENCY + 3);

    // Step count above MAX_K clamps
    for (int i = 0; i < MAX_K; i++) res_q.push_back({1'b0, 32'h4200_0000 + 32'(i)});
    start_job(3'd3, KW'(20), 32'h3F80_0000, 8'h99, MAX_K, 0);
    finish_job(0, MAX_K);
    chk("clamp_rsp_lit", rsp_data, 32'h4200_000F);

    // Reset while a step is in flight; the late result must be ignored
    res_q.push_back({1'b0, 32'h4444_4444});
    start_job(3'd1, KW'(1), 32'h3F80_0000, 8'h21, 1, 0);
    w = 0;
    while (dp_cnt == 0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("rstjob_issued", dp_cnt, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    m_wait = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_req_ready", req_ready, 1'b1);
    chk("midrst_op_ready", op_ready, 1'b0);
    chk("midrst_rsp_valid", rsp_valid, 1'b0);
    chk("midrst_rsp_data", rsp_data, 32'h0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("late_res_rsp_valid", rsp_valid, 1'b0);
      chk("late_res_req_ready", req_ready, 1'b1);
    end
    res_q.push_back({1'b0, 32'h3D00_0000});
    start_job(3'd1, KW'(1), 32'h3C00_0000, 8'h22, 1, 0);
    finish_job(0, 1);
    chk("post_rst_c_lit", dpc_q[0], 32'h3C00_0000);
    chk("post_rst_rsp_lit", rsp_data, 32'h3D00_0000);

    // BF8, first beat fully masked
    mask_tab[0] = '0;
`ifdef TCU_DRL_ZERO_SKIP_EN
    res_q.push_back({1'b0, 32'h4500_0000});
    start_job(3'd4, KW'(2), 32'h4000_0000, 8'hB8, 2, 0);
    finish_job(0, 1);
`else
    res_q.push_back({1'b0, 32'h4400_0000});
    res_q.push_back({1'b0, 32'h4500_0000});
    start_job(3'd4, KW'(2), 32'h4000_0000, 8'hB8, 2, 0);
    finish_job(0, 2);
`endif
    chk("mask0_rsp_lit", rsp_data, 32'h4500_0000);
    mask_tab[0] = '1;

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
